seq_det_arbiter: RTL
====================

# seq_det_arbiter

Round-robin controller sharing one two-consecutive-ones sequence detector among NREQ serial bit-stream requesters. It grants one requester at a time and clears the detector before each burst. It streams the granted requester's bits into the detector one bit per cycle, counts detections over the burst, and reports the count with the requester ID. It sits between the requesting bit sources and the detector datapath.

## Interface
- NREQ, 4, number of requesters (2..16)
- CNT_W, 8, width of hit counter
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; must stay high for the whole burst
- bit_in  in  NREQ  per-requester serial data bit, sampled only while that requester's gnt is high
- last  in  NREQ  marks the current bit_in as the final bit of the burst
- gnt  out  NREQ  one-hot grant, registered
- busy  out  1  high in STREAM and REPORT
- done  out  1  one-cycle pulse in REPORT
- done_id  out  $clog2(NREQ)  ID of the requester whose burst finished; valid with done
- hits  out  CNT_W  detection count for the finished burst; valid with done
- aborted  out  1  burst ended by req drop rather than last; valid with done

## Operation
- The FSM has three states: IDLE, STREAM and REPORT.
- **IDLE:**
  - If no req bit is set, stay in IDLE.
  - If any req bit is set, pick the winner by round-robin. The search starts at ptr+1 and wraps modulo NREQ.
  - Load gnt with the winner's one-hot code.
  - Synchronously clear the core to state A and set the hit counter to 0.
  - Go to STREAM.
- **STREAM:**
  - With g the granted ID, each cycle feeds w = bit_in[g] to the core.
  - A hit is defined as w=1 while the core is in B or C, i.e. core next state = C. Each hit increments the counter, saturating at 2^CNT_W-1.
  - If req[g]=0: do not sample bit_in, set aborted=1, go to REPORT.
  - Else if last[g]=1: sample the bit (it counts), set aborted=0, go to REPORT.
  - Else stay in STREAM.
  - Abort wins over a simultaneous last.
- **REPORT:**
  - gnt=0, done=1, done_id=g.
  - hits holds the final count.
  - ptr <= g.
  - Go to IDLE.
- Core detector behaviour:
  - States A (00), B (01), C (10).
  - w=1 advances A to B, B to C, and keeps C in C.
  - w=0 returns to A from any state.
  - The core's clear input forces A.
- Requests that arrive while busy wait in IDLE arbitration. A requester that is denied is not required to hold its req.
- Example count: the sequence 1,1,1 gives hits = 2.

## Timing
- Reset is asynchronous.
  - Values while resetn=0: state=IDLE, gnt=0, busy=0, done=0, done_id=0, hits=0, aborted=0, core=A.
  - ptr resets to NREQ-1, so requester 0 has first priority.
- Reset asserted mid-burst drops gnt immediately. The interrupted burst produces no done.
- Grant latency: req rising in cycle t is sampled in IDLE at edge t+1, and gnt is high from cycle t+1.
- The requester drives bit_in[g] and last[g] in every cycle where gnt[g]=1. One bit is consumed per gnt cycle, with no stall.
- Burst timing for a burst of L bits:
  - gnt is high for exactly L cycles.
  - done is asserted in the cycle after the last bit.
  - IDLE is entered the cycle after that.
  - Total occupancy is L+2 cycles, including the IDLE decision cycle.
- done_id, hits and aborted are registered. They hold their values after done until the next REPORT, except that hits is cleared at grant.
- gnt is never high in IDLE or REPORT, and at most one gnt bit is set.

## Structure
- Package seq_det_pkg holds:
  - the core state encodings A/B/C
  - the controller state enum IDLE/STREAM/REPORT
  - a function returning the ID width for NREQ
- Sub-module seq_det_core: the 3-state detector with inputs clock, resetn, clr and w, and outputs z (state==C) and hit (w && state!=A).
- The top level contains the arbiter FSM, the round-robin pointer, the priority search and the saturating counter.

## Test plan
- Req0 only, bits 1,1,1,0,1,1 with last on the 6th bit: gnt0 high for 6 cycles, then done=1, done_id=0, hits=3, aborted=0.
- req0 and req2 rise in the same cycle after reset: req0 is served first, then req2. Then all req high: order is 3, 0, 1, 2.
- Single-bit burst (1, last) on req1: gnt high for 1 cycle, done with hits=0, back in IDLE 3 cycles after the request is sampled.
- Req1 sends 1,1,1, then req1 drops with last=1 on the 4th cycle: aborted=1, hits=2, the 4th bit is not counted.
- CNT_W=3, req3 sends 10 ones: hits=7 (saturated), no wrap to 0.
- resetn pulsed low mid-STREAM on req2: gnt=0 immediately, no done; the next grant with all req high goes to req0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the round-robin two-ones detector arbiter: core and
// controller state encodings plus the requester-ID width helper.
package seq_det_pkg;

    typedef enum logic [1:0] {
        CORE_A = 2'b00,
        CORE_B = 2'b01,
        CORE_C = 2'b10
    } core_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        REPORT = 2'b10
    } ctrl_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Three-state two-consecutive-ones detector with synchronous clear.
// hit flags that the current bit moves the core into C.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic w,
    output logic z,
    output logic hit
);

    core_state_e state_q, state_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= CORE_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = CORE_A;
        if (!clr && w) begin
            case (state_q)
                CORE_A:  state_d = CORE_B;
                CORE_B:  state_d = CORE_C;
                CORE_C:  state_d = CORE_C;
                default: state_d = CORE_A;
            endcase
        end
    end

    assign z   = (state_q == CORE_C);
    assign hit = w && (state_q != CORE_A);

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin controller streaming one requester's serial burst at a time
// through a shared detector core and reporting the saturated hit count.
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned ID_W  = id_width(NREQ)
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          bit_in,
    input  logic [NREQ-1:0]          last,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [CNT_W-1:0]         hits,
    output logic                     aborted
);

    ctrl_state_e      state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic             aborted_q, aborted_d;

    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             sample;
    logic             core_w;
    logic             core_clr;
    logic             core_hit;
    logic             unused_core_z;

    // An aborting cycle must not reach the core, so w is gated by req[g].
    assign sample   = (state_q == STREAM) && req[gid_q];
    assign core_w   = sample && bit_in[gid_q];
    assign core_clr = (state_q == IDLE);

    seq_det_core u_core (
        .clock  (clock),
        .resetn (resetn),
        .clr    (core_clr),
        .w      (core_w),
        .z      (unused_core_z),
        .hit    (core_hit)
    );

    always_comb begin
        logic [ID_W-1:0] cand;
        winner  = ptr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((ptr_q + k) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gid_q     <= '0;
            ptr_q     <= ID_W'(NREQ - 1);
            done_id_q <= '0;
            hits_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
            done_id_q <= done_id_d;
            hits_q    <= hits_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        done_id_d = done_id_q;
        hits_d    = hits_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = NREQ'(1) << winner;
                    gid_d   = winner;
                    hits_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (core_hit && (hits_q != '1)) begin
                    hits_d = hits_q + 1'b1;
                end
                if (!req[gid_q]) begin
                    aborted_d = 1'b1;
                    done_id_d = gid_q;
                    gnt_d     = '0;
                    state_d   = REPORT;
                end else if (last[gid_q]) begin
                    aborted_d = 1'b0;
                    done_id_d = gid_q;
                    gnt_d     = '0;
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                ptr_d   = gid_q;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == REPORT);
    assign done_id = done_id_q;
    assign hits    = hits_q;
    assign aborted = aborted_q;

endmodule
